// File: rtl/host_itf_pkg.sv
// Shared types and constants for the host-side bus scheduler: FSM states,
// per-requester ISA tables and chip command field offsets.
package host_itf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISA,
    ST_CMD,
    ST_RD,
    ST_WR
  } hostState_e;

  localparam int unsigned ISA_TBL_NUM = 6;
  localparam int unsigned ISA_BASE [ISA_TBL_NUM] = '{0, 16, 18, 20, 29, 31};
  localparam int unsigned ISA_NUM  [ISA_TBL_NUM] = '{16, 2, 2, 9, 2, 1};

  // Command word: bit0 dir, then base address, then length in words.
  localparam int unsigned CMD_DIR_BIT  = 0;
  localparam int unsigned CMD_BASE_LSB = 1;

  function automatic int unsigned isaBase(input int unsigned idx);
    return (idx < ISA_TBL_NUM) ? ISA_BASE[idx] : 0;
  endfunction

  function automatic int unsigned isaNum(input int unsigned idx);
    return (idx < ISA_TBL_NUM) ? ISA_NUM[idx] : 0;
  endfunction

endpackage

// File: rtl/host_itf_prefetch_fifo.sv
// Two-entry prefetch FIFO holding memory read data ahead of the chip handshake.
module host_itf_prefetch_fifo
  import host_itf_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             I_OffClk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushDat,
  input  logic             pop,
  output logic [WIDTH-1:0] popDat,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wrPtr;
  logic             rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign popDat = mem[rdPtr];

  always_ff @(posedge I_OffClk or posedge rst_n) begin
    if (rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushDat;
        wrPtr      <= ~wrPtr;
      end
      if (doPop) rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/host_itf_sched.sv
// Host-side owner of the shared chip bus: round-robin ISA fetch plus chip
// read/write commands. Optional perf counters under HOST_ITF_PERF_EN.
module host_itf_sched
  import host_itf_pkg::*;
#(
  parameter int PORT_WIDTH      = 128,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int OPNUM           = 6
) (
  input  logic                       I_OffClk,
  input  logic                       rst_n,
  input  logic [OPNUM-1:0]           I_CfgRdy,
  input  logic                       I_CmdVld,
  input  logic [PORT_WIDTH-1:0]      I_ChipDat,
  input  logic                       I_ChipVld,
  input  logic                       I_ChipRdy,
  output logic [PORT_WIDTH-1:0]      O_HostDat,
  output logic                       O_HostVld,
  output logic                       O_HostLast,
  output logic                       O_HostRdy,
  output logic                       O_ISAVld,
  output logic [$clog2(OPNUM)-1:0]   O_GntIdx,
  output logic                       O_MemRdEn,
  output logic [DRAM_ADDR_WIDTH-1:0] O_MemRdAddr,
  input  logic [PORT_WIDTH-1:0]      I_MemRdDat,
  output logic                       O_MemWrEn,
  output logic [DRAM_ADDR_WIDTH-1:0] O_MemWrAddr,
  output logic [PORT_WIDTH-1:0]      O_MemWrDat,
  output logic                       O_Busy
`ifdef HOST_ITF_PERF_EN
  ,
  output logic [31:0]                O_PerfIsaBeats,
  output logic [31:0]                O_PerfRdBeats,
  output logic [31:0]                O_PerfWrBeats,
  output logic [31:0]                O_PerfStall
`endif
);

  localparam int GW      = $clog2(OPNUM);
  localparam int LEN_LSB = CMD_BASE_LSB + DRAM_ADDR_WIDTH;

  hostState_e state, stateNxt;

  logic [GW-1:0]              rrPtr;
  logic [GW-1:0]              gnt;
  logic [GW-1:0]              reqIdx;
  logic                       reqHit;
  int unsigned                rrIdx;
  logic [DRAM_ADDR_WIDTH-1:0] baseAddr;
  logic [ADDR_WIDTH-1:0]      xferLen;
  logic [ADDR_WIDTH-1:0]      issueCnt;
  logic [ADDR_WIDTH-1:0]      beatCnt;
  logic                       rdInflight;

  logic                       rdPath;
  logic                       hostVld;
  logic                       accept;
  logic                       lastBeat;
  logic                       issue;
  logic                       spaceOk;
  logic                       wrBeat;
  logic                       cmdAccept;
  logic                       isaStart;
  logic [2:0]                 occ;

  logic                       cmdDir;
  logic [DRAM_ADDR_WIDTH-1:0] cmdBase;
  logic [ADDR_WIDTH-1:0]      cmdLen;

  logic [PORT_WIDTH-1:0]      fifoHead;
  logic                       fifoFull;
  logic                       fifoEmpty;
  logic [1:0]                 fifoCount;

  assign cmdDir  = I_ChipDat[CMD_DIR_BIT];
  assign cmdBase = I_ChipDat[CMD_BASE_LSB +: DRAM_ADDR_WIDTH];
  assign cmdLen  = I_ChipDat[LEN_LSB +: ADDR_WIDTH];

  assign rdPath    = (state == ST_ISA) || (state == ST_RD);
  assign hostVld   = rdPath && !fifoEmpty;
  assign accept    = hostVld && I_ChipRdy;
  assign lastBeat  = (beatCnt == xferLen - 1'b1);
  assign wrBeat    = (state == ST_WR) && I_ChipVld;
  assign cmdAccept = (state == ST_CMD) && I_ChipVld;
  assign isaStart  = (state == ST_IDLE) && !I_CmdVld && reqHit;

  // Reads in flight count against FIFO space; a pop this cycle frees a slot.
  assign occ     = 3'(fifoCount) + 3'(rdInflight);
  assign spaceOk = accept || (!fifoFull && (occ < 3'd2));
  assign issue   = rdPath && (issueCnt != xferLen) && spaceOk;

  always_comb begin
    reqHit = 1'b0;
    reqIdx = '0;
    rrIdx  = 0;
    for (int unsigned i = 0; i < OPNUM; i++) begin
      rrIdx = (32'(rrPtr) + i) % 32'(OPNUM);
      if (!reqHit && I_CfgRdy[rrIdx]) begin
        reqHit = 1'b1;
        reqIdx = GW'(rrIdx);
      end
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE: begin
        if (I_CmdVld)    stateNxt = ST_CMD;
        else if (reqHit) stateNxt = ST_ISA;
      end
      ST_ISA, ST_RD: begin
        if (accept && lastBeat) stateNxt = ST_IDLE;
      end
      ST_CMD: begin
        if (I_ChipVld) begin
          if (cmdLen == '0) stateNxt = ST_IDLE;
          else if (cmdDir)  stateNxt = ST_WR;
          else              stateNxt = ST_RD;
        end
      end
      ST_WR: begin
        if (wrBeat && lastBeat) stateNxt = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_OffClk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      rrPtr      <= '0;
      gnt        <= '1;
      baseAddr   <= '0;
      xferLen    <= '0;
      issueCnt   <= '0;
      beatCnt    <= '0;
      rdInflight <= 1'b0;
    end else begin
      state      <= stateNxt;
      rdInflight <= issue;
      if (isaStart) begin
        gnt      <= reqIdx;
        rrPtr    <= (reqIdx == GW'(OPNUM - 1)) ? '0 : reqIdx + 1'b1;
        baseAddr <= DRAM_ADDR_WIDTH'(isaBase(32'(reqIdx)));
        xferLen  <= ADDR_WIDTH'(isaNum(32'(reqIdx)));
        issueCnt <= '0;
        beatCnt  <= '0;
      end else if (cmdAccept) begin
        baseAddr <= cmdBase;
        xferLen  <= cmdLen;
        issueCnt <= '0;
        beatCnt  <= '0;
      end else begin
        if (issue)            issueCnt <= issueCnt + 1'b1;
        if (accept || wrBeat) beatCnt  <= beatCnt + 1'b1;
      end
    end
  end

  host_itf_prefetch_fifo #(
    .WIDTH (PORT_WIDTH)
  ) u_fifo (
    .I_OffClk (I_OffClk),
    .rst_n    (rst_n),
    .push     (rdInflight),
    .pushDat  (I_MemRdDat),
    .pop      (accept),
    .popDat   (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign O_HostDat   = hostVld ? fifoHead : '0;
  assign O_HostVld   = hostVld;
  assign O_HostLast  = hostVld && lastBeat;
  assign O_HostRdy   = (state == ST_CMD) || (state == ST_WR);
  assign O_ISAVld    = (state == ST_ISA);
  assign O_GntIdx    = (state == ST_ISA) ? gnt : '1;
  assign O_MemRdEn   = issue;
  assign O_MemRdAddr = issue ? (baseAddr + DRAM_ADDR_WIDTH'(issueCnt)) : '0;
  assign O_MemWrEn   = wrBeat;
  assign O_MemWrAddr = wrBeat ? (baseAddr + DRAM_ADDR_WIDTH'(beatCnt)) : '0;
  assign O_MemWrDat  = wrBeat ? I_ChipDat : '0;
  assign O_Busy      = (state != ST_IDLE);

`ifdef HOST_ITF_PERF_EN
  always_ff @(posedge I_OffClk or posedge rst_n) begin
    if (rst_n) begin
      O_PerfIsaBeats <= '0;
      O_PerfRdBeats  <= '0;
      O_PerfWrBeats  <= '0;
      O_PerfStall    <= '0;
    end else begin
      if (accept && (state == ST_ISA) && (O_PerfIsaBeats != '1))
        O_PerfIsaBeats <= O_PerfIsaBeats + 32'd1;
      if (accept && (state == ST_RD) && (O_PerfRdBeats != '1))
        O_PerfRdBeats <= O_PerfRdBeats + 32'd1;
      if (wrBeat && (O_PerfWrBeats != '1))
        O_PerfWrBeats <= O_PerfWrBeats + 32'd1;
      if (hostVld && !I_ChipRdy && (O_PerfStall != '1))
        O_PerfStall <= O_PerfStall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_host_itf_sched.sv
// Scoreboard bench for host_itf_sched: expected beats and memory writes are
// queued at stimulus time and checked as the DUT produces them.
module tb_host_itf_sched;
  import host_itf_pkg::*;

  typedef struct packed {
    logic [127:0] dat;
    logic         last;
    logic         isa;
    logic [2:0]   gnt;
  } beat_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] dat;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   I_CfgRdy;
  logic         I_CmdVld;
  logic [127:0] I_ChipDat;
  logic         I_ChipVld;
  logic         I_ChipRdy;
  logic [127:0] O_HostDat;
  logic         O_HostVld;
  logic         O_HostLast;
  logic         O_HostRdy;
  logic         O_ISAVld;
  logic [2:0]   O_GntIdx;
  logic         O_MemRdEn;
  logic [31:0]  O_MemRdAddr;
  logic [127:0] memRdDat;
  logic         O_MemWrEn;
  logic [31:0]  O_MemWrAddr;
  logic [127:0] O_MemWrDat;
  logic         O_Busy;
`ifdef HOST_ITF_PERF_EN
  logic [31:0]  perfIsa, perfRd, perfWr, perfStall;
`endif

  int    nChecks = 0;
  int    nFails  = 0;
  int    wrPulses = 0;
  beat_t expQ [$];
  wr_t   wrQ  [$];
  beat_t monBeat;
  wr_t   monWr;

  always #5 clk = ~clk;

  host_itf_sched #(
    .PORT_WIDTH      (128),
    .DRAM_ADDR_WIDTH (32),
    .ADDR_WIDTH      (16),
    .OPNUM           (6)
  ) dut (
    .I_OffClk    (clk),
    .rst_n       (rst_n),
    .I_CfgRdy    (I_CfgRdy),
    .I_CmdVld    (I_CmdVld),
    .I_ChipDat   (I_ChipDat),
    .I_ChipVld   (I_ChipVld),
    .I_ChipRdy   (I_ChipRdy),
    .O_HostDat   (O_HostDat),
    .O_HostVld   (O_HostVld),
    .O_HostLast  (O_HostLast),
    .O_HostRdy   (O_HostRdy),
    .O_ISAVld    (O_ISAVld),
    .O_GntIdx    (O_GntIdx),
    .O_MemRdEn   (O_MemRdEn),
    .O_MemRdAddr (O_MemRdAddr),
    .I_MemRdDat  (memRdDat),
    .O_MemWrEn   (O_MemWrEn),
    .O_MemWrAddr (O_MemWrAddr),
    .O_MemWrDat  (O_MemWrDat),
    .O_Busy      (O_Busy)
`ifdef HOST_ITF_PERF_EN
    ,
    .O_PerfIsaBeats (perfIsa),
    .O_PerfRdBeats  (perfRd),
    .O_PerfWrBeats  (perfWr),
    .O_PerfStall    (perfStall)
`endif
  );

  function automatic logic [127:0] memFn(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a * 32'd3, a + 32'h1234_5678};
  endfunction

  // Synchronous memory model: data one cycle after the read enable.
  always_ff @(posedge clk) begin
    if (O_MemRdEn) memRdDat <= memFn(O_MemRdAddr);
  end

  task automatic chkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n && O_HostVld && I_ChipRdy) begin
      if (expQ.size() == 0) chkEq("extra_beat", 1, 0);
      else begin
        monBeat = expQ.pop_front();
        chkEq("beat_dat",  O_HostDat,  monBeat.dat);
        chkEq("beat_last", O_HostLast, monBeat.last);
        chkEq("beat_isa",  O_ISAVld,   monBeat.isa);
        chkEq("beat_gnt",  O_GntIdx,   monBeat.gnt);
      end
    end
    if (!rst_n && O_MemWrEn) begin
      wrPulses++;
      if (wrQ.size() == 0) chkEq("extra_write", 1, 0);
      else begin
        monWr = wrQ.pop_front();
        chkEq("wr_addr", O_MemWrAddr, monWr.addr);
        chkEq("wr_dat",  O_MemWrDat,  monWr.dat);
      end
    end
  end

  task automatic pushIsa(input int g);
    int unsigned n = isaNum(g);
    for (int unsigned k = 0; k < n; k++)
      expQ.push_back('{memFn(isaBase(g) + k), (k == n - 1), 1'b1, 3'(g)});
  endtask

  task automatic pushRd(input logic [31:0] base, input int len);
    for (int k = 0; k < len; k++)
      expQ.push_back('{memFn(base + 32'(k)), (k == len - 1), 1'b0, 3'b111});
  endtask

  task automatic doCmd(input logic dir, input logic [31:0] base, input logic [15:0] len);
    int n = 0;
    I_ChipDat        = '0;
    I_ChipDat[0]     = dir;
    I_ChipDat[32:1]  = base;
    I_ChipDat[48:33] = len;
    I_CmdVld  = 1'b1;
    I_ChipVld = 1'b1;
    @(negedge clk);
    while (!O_HostRdy && n < 20) begin @(negedge clk); n++; end
    chkEq("cmd_rdy", O_HostRdy, 1);
    @(posedge clk); #1;
    I_CmdVld  = 1'b0;
    I_ChipVld = 1'b0;
    I_ChipDat = '0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (O_Busy && n < budget) begin @(negedge clk); n++; end
    chkEq({tag, "_idle"}, O_Busy, 0);
  endtask

  task automatic waitQ(input string tag, input int lim, input int budget);
    int n = 0;
    while (expQ.size() > lim && n < budget) begin @(negedge clk); n++; end
    chkEq({tag, "_progress"}, (n < budget), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]   pat;
    logic [127:0] wd [3];
    int n;
    pat = 4'b1001;
    wd[0] = {4{32'hAAAA_0001}};
    wd[1] = {4{32'hBBBB_0002}};
    wd[2] = {4{32'hCCCC_0003}};
    rst_n = 1'b1;
    I_CfgRdy = '0; I_CmdVld = 1'b0; I_ChipDat = '0; I_ChipVld = 1'b0; I_ChipRdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkEq("rst_hostvld", O_HostVld, 0);
    chkEq("rst_hostrdy", O_HostRdy, 0);
    chkEq("rst_isavld",  O_ISAVld,  0);
    chkEq("rst_gnt",     O_GntIdx,  3'b111);
    chkEq("rst_rden",    O_MemRdEn, 0);
    chkEq("rst_wren",    O_MemWrEn, 0);
    chkEq("rst_busy",    O_Busy,    0);
    chkEq("rst_dat",     O_HostDat, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Round-robin between requesters 0 and 3.
    pushIsa(0); pushIsa(3); pushIsa(0);
    I_CfgRdy = 6'b001001;
    waitQ("t1", 15, 400);
    I_CfgRdy = '0;
    waitIdle("t1", 100);
    chkEq("t1_drain", expQ.size(), 0);
    chkEq("t1_gnt_none", O_GntIdx, 3'b111);

    @(posedge clk); #1;
    pushRd(32'd100, 4);
    doCmd(1'b0, 32'd100, 16'd4);
    waitIdle("t2", 50);
    chkEq("t2_drain", expQ.size(), 0);

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) wrQ.push_back('{32'd200 + 32'(i), wd[i]});
    wrPulses = 0;
    doCmd(1'b1, 32'd200, 16'd3);
    for (int i = 0; i < 3; i++) begin
      I_ChipDat = wd[i];
      I_ChipVld = 1'b1;
      @(posedge clk); #1;
    end
    I_ChipVld = 1'b0;
    I_ChipDat = '0;
    waitIdle("t3", 20);
    chkEq("t3_pulses", wrPulses, 3);
    chkEq("t3_drain", wrQ.size(), 0);

    // Read burst under toggling backpressure.
    @(posedge clk); #1;
    pushRd(32'd400, 8);
    doCmd(1'b0, 32'd400, 16'd8);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      I_ChipRdy = pat[c % 4];
      @(posedge clk); #1;
      n = c;
      if (!O_Busy) break;
    end
    I_ChipRdy = 1'b1;
    chkEq("t4_done", (n < 99), 1);
    chkEq("t4_drain", expQ.size(), 0);

    @(posedge clk); #1;
    doCmd(1'b0, 32'd500, 16'd0);
    @(negedge clk);
    chkEq("t_len0_idle", O_Busy, 0);
    chkEq("t_len0_novld", O_HostVld, 0);

    // Command and ISA request arrive together: command first.
    @(posedge clk); #1;
    pushRd(32'd300, 2);
    pushIsa(2);
    I_CfgRdy = 6'b000100;
    doCmd(1'b0, 32'd300, 16'd2);
    n = 0;
    while (O_GntIdx != 3'd2 && n < 100) begin @(negedge clk); n++; end
    chkEq("t5_gnt2", O_GntIdx, 3'd2);
    I_CfgRdy = '0;
    waitIdle("t5", 50);
    chkEq("t5_drain", expQ.size(), 0);

    // Reset in the middle of a 16-word ISA burst.
    @(posedge clk); #1;
    pushIsa(0);
    I_CfgRdy = 6'b000001;
    waitQ("t6a", 11, 200);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chkEq("t6_rst_vld",  O_HostVld,  0);
    chkEq("t6_rst_last", O_HostLast, 0);
    chkEq("t6_rst_gnt",  O_GntIdx,   3'b111);
    chkEq("t6_rst_busy", O_Busy,     0);
    chkEq("t6_rst_rden", O_MemRdEn,  0);
    chkEq("t6_rst_dat",  O_HostDat,  0);
    expQ.delete();
    pushIsa(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    waitQ("t6b", 15, 200);
    I_CfgRdy = '0;
    waitIdle("t6", 100);
    chkEq("t6_drain", expQ.size(), 0);

    chkEq("end_wrq", wrQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
